// File: rtl/multicycle_control_fsm_pkg.sv
// Shared encodings for the multicycle MIPS control sequencer: state, opcode,
// ALU and mux-select codes.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_FETCH     = 4'd0,
        ST_DECODE    = 4'd1,
        ST_R_EXEC    = 4'd2,
        ST_R_WB      = 4'd3,
        ST_I_EXEC    = 4'd4,
        ST_I_WB      = 4'd5,
        ST_MEM_ADDR  = 4'd6,
        ST_MEM_READ  = 4'd7,
        ST_MEM_WB    = 4'd8,
        ST_MEM_WRITE = 4'd9,
        ST_BRANCH    = 4'd10,
        ST_JUMP      = 4'd11,
        ST_ILLEGAL   = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [2:0] ALUOP_ADD   = 3'b000;
    localparam logic [2:0] ALUOP_SUB   = 3'b001;
    localparam logic [2:0] ALUOP_OR    = 3'b010;
    localparam logic [2:0] ALUOP_FUNCT = 3'b111;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] ALUB_REG     = 2'b00;
    localparam logic [1:0] ALUB_FOUR    = 2'b01;
    localparam logic [1:0] ALUB_IMM     = 2'b10;
    localparam logic [1:0] ALUB_IMM_SH2 = 2'b11;

    function automatic logic is_mem_state(input state_t s);
        return (s == ST_FETCH) || (s == ST_MEM_READ) || (s == ST_MEM_WRITE);
    endfunction

endpackage

// File: rtl/multicycle_control_fsm_wait_counter.sv
// Memory-state dwell counter; last_o flags the exit cycle (count == MEM_LATENCY-1).
// Single-cycle clear/increment, no backpressure; clear wins over increment.
module mc_wait_counter #(
    parameter int MEM_LATENCY = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    input  logic inc_i,
    output logic last_o
);

    logic [3:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = 4'd0;
        end else if (inc_i) begin
            cnt_d = cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign last_o = (cnt_q == 4'(MEM_LATENCY - 1));

endmodule

// File: rtl/multicycle_control_fsm.sv
// Moore control FSM for the multicycle MIPS datapath, 3-5 cycles per instruction
// plus MEM_LATENCY-1 per memory state; no backpressure beyond the fixed memory wait.
module multicycle_control_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int MEM_LATENCY = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       zero,
    output logic       pc_en,
    output logic [1:0] pc_src,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_op,
    output logic       extend_side,
    output logic       instr_done,
    output logic       illegal_op,
    output logic [3:0] state_out
);

    state_t     state_q, state_d;
    logic [5:0] op_q, op_d;
    logic       wait_last;

    mc_wait_counter #(.MEM_LATENCY(MEM_LATENCY)) u_wait (
        .clk    (clk),
        .reset  (reset),
        .clr_i  (state_d != state_q),
        .inc_i  (is_mem_state(state_q)),
        .last_o (wait_last)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_FETCH;
            op_q    <= 6'd0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
        end
    end

    // Opcode is captured on leaving DECODE so later states ignore IR changes.
    assign op_d = (state_q == ST_DECODE) ? opcode : op_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FETCH:     if (wait_last) state_d = ST_DECODE;
            ST_DECODE: begin
                case (opcode)
                    OP_RTYPE:        state_d = ST_R_EXEC;
                    OP_ADDI, OP_ORI: state_d = ST_I_EXEC;
                    OP_LW, OP_SW:    state_d = ST_MEM_ADDR;
                    OP_BEQ, OP_BNE:  state_d = ST_BRANCH;
                    OP_J:            state_d = ST_JUMP;
                    default:         state_d = ST_ILLEGAL;
                endcase
            end
            ST_R_EXEC:    state_d = ST_R_WB;
            ST_I_EXEC:    state_d = ST_I_WB;
            ST_MEM_ADDR:  state_d = (op_q == OP_LW) ? ST_MEM_READ : ST_MEM_WRITE;
            ST_MEM_READ:  if (wait_last) state_d = ST_MEM_WB;
            ST_MEM_WRITE: if (wait_last) state_d = ST_FETCH;
            ST_R_WB, ST_I_WB, ST_MEM_WB, ST_BRANCH, ST_JUMP: state_d = ST_FETCH;
            ST_ILLEGAL:   state_d = ST_ILLEGAL;
            default:      state_d = ST_FETCH;
        endcase
    end

    always_comb begin
        pc_en       = 1'b0;
        pc_src      = PCSRC_ALU;
        iord        = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        ir_write    = 1'b0;
        reg_dst     = 1'b0;
        mem_to_reg  = 1'b0;
        reg_write   = 1'b0;
        alu_src_a   = 1'b0;
        alu_src_b   = ALUB_REG;
        alu_op      = ALUOP_ADD;
        extend_side = 1'b0;
        instr_done  = 1'b0;
        illegal_op  = 1'b0;
        case (state_q)
            ST_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = ALUB_FOUR;
                ir_write  = wait_last;
                pc_en     = wait_last;
            end
            ST_DECODE:    alu_src_b = ALUB_IMM_SH2;
            ST_R_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = ALUOP_FUNCT;
            end
            ST_R_WB: begin
                reg_dst    = 1'b1;
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            ST_I_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = ALUB_IMM;
                if (op_q == OP_ORI) begin
                    alu_op      = ALUOP_OR;
                    extend_side = 1'b1;
                end
            end
            ST_I_WB, ST_MEM_WB: begin
                mem_to_reg = (state_q == ST_MEM_WB);
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            ST_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = ALUB_IMM;
            end
            ST_MEM_READ: begin
                iord     = 1'b1;
                mem_read = 1'b1;
            end
            ST_MEM_WRITE: begin
                iord       = 1'b1;
                mem_write  = wait_last;
                instr_done = wait_last;
            end
            ST_BRANCH: begin
                alu_src_a  = 1'b1;
                alu_op     = ALUOP_SUB;
                pc_src     = PCSRC_ALUOUT;
                pc_en      = ((op_q == OP_BEQ) && zero) || ((op_q == OP_BNE) && !zero);
                instr_done = 1'b1;
            end
            ST_JUMP: begin
                pc_src     = PCSRC_JUMP;
                pc_en      = 1'b1;
                instr_done = 1'b1;
            end
            ST_ILLEGAL:   illegal_op = 1'b1;
            default: ;
        endcase
        // Reset masks every strobe and select combinationally, aborting any write.
        if (!reset) begin
            pc_en       = 1'b0;
            pc_src      = 2'b00;
            iord        = 1'b0;
            mem_read    = 1'b0;
            mem_write   = 1'b0;
            ir_write    = 1'b0;
            reg_dst     = 1'b0;
            mem_to_reg  = 1'b0;
            reg_write   = 1'b0;
            alu_src_a   = 1'b0;
            alu_src_b   = 2'b00;
            alu_op      = 3'b000;
            extend_side = 1'b0;
            instr_done  = 1'b0;
            illegal_op  = 1'b0;
        end
    end

    assign state_out = state_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed vector bench for multicycle_control_fsm at MEM_LATENCY 1 and 3.
module tb_multicycle_control_fsm;
    import mc_ctrl_pkg::*;

    typedef struct packed {
        logic [3:0] state;
        logic       pc_en;
        logic [1:0] pc_src;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic       extend_side;
        logic       instr_done;
        logic       illegal_op;
    } outs_t;

    typedef struct {
        logic       rst;
        logic [5:0] op;
        logic       z;
        outs_t      exp;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [5:0] opcode = 6'd0;
    logic       zero = 1'b0;

    logic       a_pc_en, a_iord, a_mr, a_mw, a_irw, a_rdst, a_m2r, a_rw, a_asa, a_ext, a_done, a_ill;
    logic [1:0] a_pc_src, a_asb;
    logic [2:0] a_aop;
    logic [3:0] a_state;
    logic       b_pc_en, b_iord, b_mr, b_mw, b_irw, b_rdst, b_m2r, b_rw, b_asa, b_ext, b_done, b_ill;
    logic [1:0] b_pc_src, b_asb;
    logic [2:0] b_aop;
    logic [3:0] b_state;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    multicycle_control_fsm #(.MEM_LATENCY(1)) dut1 (
        .clk(clk), .reset(reset), .opcode(opcode), .zero(zero),
        .pc_en(a_pc_en), .pc_src(a_pc_src), .iord(a_iord), .mem_read(a_mr),
        .mem_write(a_mw), .ir_write(a_irw), .reg_dst(a_rdst), .mem_to_reg(a_m2r),
        .reg_write(a_rw), .alu_src_a(a_asa), .alu_src_b(a_asb), .alu_op(a_aop),
        .extend_side(a_ext), .instr_done(a_done), .illegal_op(a_ill), .state_out(a_state)
    );

    multicycle_control_fsm #(.MEM_LATENCY(3)) dut3 (
        .clk(clk), .reset(reset), .opcode(opcode), .zero(zero),
        .pc_en(b_pc_en), .pc_src(b_pc_src), .iord(b_iord), .mem_read(b_mr),
        .mem_write(b_mw), .ir_write(b_irw), .reg_dst(b_rdst), .mem_to_reg(b_m2r),
        .reg_write(b_rw), .alu_src_a(b_asa), .alu_src_b(b_asb), .alu_op(b_aop),
        .extend_side(b_ext), .instr_done(b_done), .illegal_op(b_ill), .state_out(b_state)
    );

    outs_t act1;
    assign act1 = {a_state, a_pc_en, a_pc_src, a_iord, a_mr, a_mw, a_irw, a_rdst, a_m2r,
                   a_rw, a_asa, a_asb, a_aop, a_ext, a_done, a_ill};

    // lw at MEM_LATENCY=3: {state, ir_write, mem_read, reg_write, mem_to_reg}
    logic [7:0] lw_exp [9] = '{8'h04, 8'h04, 8'h0C, 8'h10, 8'h60, 8'h74, 8'h74, 8'h74, 8'h83};
    // sw at MEM_LATENCY=3 up to MEM_WRITE first cycle: {state, mem_write, instr_done}
    logic [5:0] sw_exp [6] = '{6'h00, 6'h00, 6'h00, 6'h04, 6'h18, 6'h24};

    task automatic check(input string nm, input logic [31:0] a, input logic [31:0] e);
        n_checks++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, a, e);
        end
    endtask

    function automatic outs_t o_base(input state_t s);
        outs_t o;
        o = '0;
        o.state = s;
        return o;
    endfunction

    vec_t vecs[$];

    task automatic add(input logic rst, input logic [5:0] op, input logic z, input outs_t e);
        vec_t v;
        v.rst = rst; v.op = op; v.z = z; v.exp = e;
        vecs.push_back(v);
    endtask

    initial begin
        outs_t o_rst, o_f, o_d, o_rex, o_rwb, o_iadd, o_iori, o_iwb;
        outs_t o_br_t, o_br_n, o_j, o_ma, o_mw, o_mr, o_mwb, o_ill;

        o_rst = o_base(ST_FETCH);
        o_f = o_base(ST_FETCH);
        o_f.mem_read = 1; o_f.alu_src_b = 2'b01; o_f.ir_write = 1; o_f.pc_en = 1;
        o_d = o_base(ST_DECODE); o_d.alu_src_b = 2'b11;
        o_rex = o_base(ST_R_EXEC); o_rex.alu_src_a = 1; o_rex.alu_op = 3'b111;
        o_rwb = o_base(ST_R_WB); o_rwb.reg_dst = 1; o_rwb.reg_write = 1; o_rwb.instr_done = 1;
        o_iadd = o_base(ST_I_EXEC); o_iadd.alu_src_a = 1; o_iadd.alu_src_b = 2'b10;
        o_iori = o_iadd; o_iori.alu_op = 3'b010; o_iori.extend_side = 1;
        o_iwb = o_base(ST_I_WB); o_iwb.reg_write = 1; o_iwb.instr_done = 1;
        o_br_n = o_base(ST_BRANCH); o_br_n.alu_src_a = 1; o_br_n.alu_op = 3'b001;
        o_br_n.pc_src = 2'b01; o_br_n.instr_done = 1;
        o_br_t = o_br_n; o_br_t.pc_en = 1;
        o_j = o_base(ST_JUMP); o_j.pc_src = 2'b10; o_j.pc_en = 1; o_j.instr_done = 1;
        o_ma = o_base(ST_MEM_ADDR); o_ma.alu_src_a = 1; o_ma.alu_src_b = 2'b10;
        o_mw = o_base(ST_MEM_WRITE); o_mw.iord = 1; o_mw.mem_write = 1; o_mw.instr_done = 1;
        o_mr = o_base(ST_MEM_READ); o_mr.iord = 1; o_mr.mem_read = 1;
        o_mwb = o_base(ST_MEM_WB); o_mwb.mem_to_reg = 1; o_mwb.reg_write = 1; o_mwb.instr_done = 1;
        o_ill = o_base(ST_ILLEGAL); o_ill.illegal_op = 1;

        add(0, OP_RTYPE, 0, o_rst);
        add(1, OP_RTYPE, 0, o_f); add(1, OP_RTYPE, 0, o_d);
        add(1, OP_RTYPE, 0, o_rex); add(1, OP_RTYPE, 0, o_rwb);
        add(1, OP_ADDI, 0, o_f); add(1, OP_ADDI, 0, o_d);
        add(1, OP_ADDI, 0, o_iadd); add(1, OP_ADDI, 0, o_iwb);
        add(1, OP_ORI, 0, o_f); add(1, OP_ORI, 0, o_d);
        add(1, OP_ADDI, 0, o_iori); add(1, 6'b111111, 0, o_iwb);
        add(1, OP_BEQ, 1, o_f); add(1, OP_BEQ, 1, o_d); add(1, OP_BEQ, 1, o_br_t);
        add(1, OP_BEQ, 0, o_f); add(1, OP_BEQ, 0, o_d); add(1, OP_BEQ, 0, o_br_n);
        add(1, OP_BNE, 1, o_f); add(1, OP_BNE, 1, o_d); add(1, OP_BNE, 1, o_br_n);
        add(1, OP_BNE, 0, o_f); add(1, OP_BNE, 0, o_d); add(1, OP_BNE, 0, o_br_t);
        add(1, OP_J, 0, o_f); add(1, OP_J, 0, o_d); add(1, OP_J, 0, o_j);
        add(1, OP_SW, 0, o_f); add(1, OP_SW, 0, o_d); add(1, OP_SW, 0, o_ma); add(1, OP_SW, 0, o_mw);
        add(1, OP_LW, 0, o_f); add(1, OP_LW, 0, o_d); add(1, OP_LW, 0, o_ma);
        add(1, OP_LW, 0, o_mr); add(1, OP_LW, 0, o_mwb);
        add(1, 6'b111111, 0, o_f); add(1, 6'b111111, 0, o_d); add(1, 6'b111111, 0, o_ill);

        reset = 1'b0;
        @(posedge clk);
        @(posedge clk);

        foreach (vecs[i]) begin
            @(negedge clk);
            reset = vecs[i].rst; opcode = vecs[i].op; zero = vecs[i].z;
            #1;
            check($sformatf("vec%0d", i), 32'(act1), 32'(vecs[i].exp));
        end

        for (int c = 0; c < 20; c++) begin
            @(negedge clk); #1;
            check($sformatf("illegal_hold%0d", c), {a_state, a_ill}, {ST_ILLEGAL, 1'b1});
        end
        @(negedge clk); reset = 1'b0; #1;
        check("illegal_in_reset", {31'd0, a_ill}, 32'd0);
        @(negedge clk); reset = 1'b1; opcode = OP_RTYPE; #1;
        check("illegal_cleared", {a_state, a_ill}, {ST_FETCH, 1'b0});

        // lw at MEM_LATENCY=3
        @(negedge clk); reset = 1'b0;
        @(negedge clk);
        for (int c = 0; c < 9; c++) begin
            if (c > 0) @(negedge clk);
            reset = 1'b1; opcode = OP_LW; #1;
            check($sformatf("lw3_cyc%0d", c + 1), {b_state, b_irw, b_mr, b_rw, b_m2r}, lw_exp[c]);
        end

        // sw at MEM_LATENCY=3, reset on the second MEM_WRITE cycle
        @(negedge clk); reset = 1'b0;
        @(negedge clk);
        for (int c = 0; c < 6; c++) begin
            if (c > 0) @(negedge clk);
            reset = 1'b1; opcode = OP_SW; #1;
            check($sformatf("sw3_cyc%0d", c + 1), {b_state, b_mw, b_done}, sw_exp[c]);
        end
        @(negedge clk); reset = 1'b0; #1;
        check("sw3_abort", {b_state, b_mw, b_done}, {ST_MEM_WRITE, 2'b00});
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); reset = 1'b1; opcode = OP_RTYPE; #1;
            check($sformatf("sw3_refetch%0d", c + 1), {b_state, b_irw, b_mw},
                  {ST_FETCH, (c == 2) ? 1'b1 : 1'b0, 1'b0});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
Multicycle sequencer for the MIPS datapath: add, sub, and, or, nor (R-type), addi, ori, beq, bne, lw, sw, j. Replaces the single-cycle combinational control decode with a Moore FSM. The FSM sequences one shared memory port, one ALU, the IR, PC and register file over 3–5 cycles per instruction. It sits between the instruction register opcode/funct fields and all datapath mux selects and write strobes.

Parameters:
MEM_LATENCY, 1, cycles each memory access (FETCH, MEM_READ, MEM_WRITE) is held; legal range 1..15.

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-low reset
opcode  in  6  IR[31:26]
zero  in  1  ALU zero flag, valid during BRANCH
pc_en  out  1  PC load strobe
pc_src  out  2  00 ALU result, 01 ALUOut register, 10 jump target {PC[31:28],IR[25:0],2'b00}
iord  out  1  memory address select: 0 PC, 1 ALUOut
mem_read  out  1  memory read enable
mem_write  out  1  memory write strobe
ir_write  out  1  instruction register load
reg_dst  out  1  0 rt, 1 rd
mem_to_reg  out  1  0 ALUOut, 1 MDR
reg_write  out  1  register file write strobe
alu_src_a  out  1  0 PC, 1 register A
alu_src_b  out  2  00 register B, 01 constant 4, 10 extended immediate, 11 extended immediate<<2
alu_op  out  3  000 add, 001 sub, 010 or, 111 decode by funct
extend_side  out  1  0 sign-extend, 1 zero-extend
instr_done  out  1  one-cycle pulse on the last cycle of each instruction
illegal_op  out  1  high while halted on an unsupported opcode
state_out  out  4  current state encoding, for debug

Behaviour:
- Reset: all strobes are forced to 0 combinationally while reset=0 (pc_en, ir_write, reg_write, mem_read, mem_write, instr_done). All selects read 0. At the clock edge the FSM enters FETCH with wait counter = 0. Reset asserted mid-instruction aborts that instruction; no partial write is issued after the edge.
- Wait counter: 4-bit. It clears on every state change and increments while in a memory state. The memory state exits when counter == MEM_LATENCY-1. Strobes marked "final" assert only on that exit cycle. mem_read stays high for the whole memory state.
- FETCH: iord=0, mem_read=1, alu_src_a=0, alu_src_b=01, alu_op=000, pc_src=00. ir_write and pc_en assert on the final cycle. Next state: DECODE.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=000 (branch target into ALUOut). Next state by opcode:
  - 000000 → R_EXEC
  - 001000 and 001101 → I_EXEC
  - 100011 and 101011 → MEM_ADDR
  - 000100 and 000101 → BRANCH
  - 000010 → JUMP
  - any other → ILLEGAL
- R_EXEC: alu_src_a=1, alu_src_b=00, alu_op=111 → R_WB.
- R_WB: reg_dst=1, mem_to_reg=0, reg_write=1, instr_done=1 → FETCH.
- I_EXEC: alu_src_a=1, alu_src_b=10. addi: alu_op=000, extend_side=0. ori: alu_op=010, extend_side=1. Next state: I_WB.
- I_WB: reg_dst=0, mem_to_reg=0, reg_write=1, instr_done=1 → FETCH. The opcode is held in a registered copy latched in DECODE, so it is immune to IR changes.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=000, extend_side=0 → MEM_READ (lw) or MEM_WRITE (sw).
- MEM_READ: iord=1, mem_read=1 → MEM_WB after the wait.
- MEM_WB: reg_dst=0, mem_to_reg=1, reg_write=1, instr_done=1 → FETCH.
- MEM_WRITE: iord=1. mem_write and instr_done assert on the final cycle only → FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=001, pc_src=01. pc_en = (beq & zero) | (bne & ~zero). instr_done=1 → FETCH.
- JUMP: pc_src=10, pc_en=1, instr_done=1 → FETCH.
- ILLEGAL: illegal_op=1 and all strobes 0. The FSM stays here until reset.
- Cycle counts at MEM_LATENCY=1: R-type, addi, ori, sw = 4; lw = 5; beq, bne, j = 3. Each memory state adds MEM_LATENCY-1 cycles.
- Any undefined state encoding transitions to FETCH on the next edge.

Decomposition:
- Shared package mc_ctrl_pkg holds:
  - the state enum (4-bit)
  - opcode constants (OP_RTYPE, OP_ADDI, OP_ORI, OP_BEQ, OP_BNE, OP_LW, OP_SW, OP_J)
  - ALUOp codes
  - pc_src and alu_src_b encodings
- One sub-module, mc_wait_counter: the parameterised latency counter with clear/increment and a "last" output.
- Output decode stays in the top module.

Test Plan:
- reset=0 for 2 cycles, then release → state_out=FETCH, all strobes 0 during reset. At MEM_LATENCY=1: ir_write=1 and pc_en=1 in the first cycle.
- Opcode 000000 → states FETCH, DECODE, R_EXEC, R_WB. reg_write=1 with reg_dst=1 on cycle 4; alu_op=111 on cycle 3; instr_done on cycle 4 only.
- Opcode 100011 with MEM_LATENCY=3 → FETCH lasts 3 cycles with ir_write only on the 3rd; MEM_READ lasts 3 cycles; reg_write with mem_to_reg=1 on cycle 9.
- beq (000100) with zero=1 → pc_en=1, pc_src=01 in BRANCH. With zero=0 → pc_en=0. bne inverts both results.
- Opcode 001101 → extend_side=1 and alu_op=010 in I_EXEC. Opcode 111111 → ILLEGAL with illegal_op held high for 20 cycles; reset clears it to FETCH.
- sw with reset dropped during MEM_WRITE before its final cycle → mem_write never asserts. The next edge gives FETCH with counter 0.
